// File: rtl/version_pkg.sv
// Build identification constants stamped into the version record.
package version_pkg;

  localparam logic [7:0]  VER_MAJOR  = 8'h00;
  localparam logic [7:0]  VER_MINOR  = 8'h00;
  localparam logic [7:0]  VER_PATCH  = 8'h00;
  localparam logic [7:0]  VER_BUILD  = 8'h31;
  localparam logic [15:0] VER_YEAR   = 16'h2025;
  localparam logic [7:0]  VER_MONTH  = 8'h11;
  localparam logic [7:0]  VER_DAY    = 8'h05;
  localparam logic [7:0]  VER_HOUR   = 8'h11;
  localparam logic [7:0]  VER_MINUTE = 8'h28;
  localparam logic [7:0]  VER_SECOND = 8'h19;

endpackage

// File: rtl/version_proto_pkg.sv
// Host protocol constants, responder FSM states and version record builder.
package version_proto_pkg;

  import version_pkg::*;

  localparam logic [7:0] CMD_VERSION_DEF = 8'h56;
  localparam logic [7:0] SOF_BYTE_DEF    = 8'hA5;
  localparam logic [7:0] LEN_BYTE        = 8'h0B;
  localparam int         PAYLOAD_BYTES   = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_t;

  // Byte 0 (major) lands in the top byte so payload byte i is bits [87-8i -: 8].
  function automatic logic [87:0] build_version_record();
    return {VER_MAJOR, VER_MINOR, VER_PATCH, VER_BUILD,
            VER_YEAR[15:8], VER_YEAR[7:0], VER_MONTH, VER_DAY,
            VER_HOUR, VER_MINUTE, VER_SECOND};
  endfunction

endpackage

// File: rtl/version_reporter.sv
// Answers a version command byte with one framed, checksummed 14-byte record:
// SOF, LEN, 11 payload bytes, CHK (LEN..CHK sums to zero mod 256).
module version_reporter
  import version_proto_pkg::*;
#(
  parameter logic [87:0] VERSION_RECORD = build_version_record(),
  parameter logic [7:0]  CMD_VERSION    = CMD_VERSION_DEF,
  parameter logic [7:0]  SOF_BYTE       = SOF_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       busy,
  output logic       cmd_drop
);

  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

  // Selects payload byte idx of the record; out-of-range indices read as zero.
  function automatic logic [7:0] payload_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (idx == 4'(k)) b = VERSION_RECORD[87 - 8*k -: 8];
    end
    return b;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       cmd_drop_q, cmd_drop_d;

  logic       xfer;
  logic       cmd_hit;
  logic [7:0] cur_byte;
  logic [7:0] acc_sum;

  assign xfer     = m_valid_q && m_ready;
  assign cmd_hit  = s_valid && (s_data == CMD_VERSION);
  assign cur_byte = payload_byte(idx_q);
  assign acc_sum  = acc_q + cur_byte;

  // Commands are never back-pressured; ready simply follows reset.
  assign s_ready  = rst_n;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign cmd_drop = cmd_drop_q;

  // Next-state, output byte and checksum accumulation; everything advances on a transfer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    // Busy includes the CHK transfer cycle, so a command then is dropped too.
    cmd_drop_d = cmd_hit && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (cmd_hit) begin
          state_d   = ST_SOF;
          m_data_d  = SOF_BYTE;
          m_valid_d = 1'b1;
          idx_d     = 4'd0;
          acc_d     = 8'h00;
        end
      end
      ST_SOF: begin
        if (xfer) begin
          state_d  = ST_LEN;
          m_data_d = LEN_BYTE;
          acc_d    = LEN_BYTE;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          state_d  = ST_PAYLOAD;
          idx_d    = 4'd0;
          m_data_d = payload_byte(4'd0);
        end
      end
      ST_PAYLOAD: begin
        if (idx_q > LAST_IDX) begin
          // Unreachable index: abandon the frame rather than emit garbage.
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          m_data_d  = 8'h00;
          idx_d     = 4'd0;
        end else if (xfer) begin
          acc_d = acc_sum;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_CHK;
            m_data_d = 8'h00 - acc_sum;
          end else begin
            idx_d    = idx_q + 4'd1;
            m_data_d = payload_byte(idx_q + 4'd1);
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          m_data_d  = 8'h00;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        m_data_d  = 8'h00;
        idx_d     = 4'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      acc_q      <= 8'h00;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      cmd_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      cmd_drop_q <= cmd_drop_d;
    end
  end

endmodule

// File: doc/version_reporter.md
Name: version_reporter

Overview:
- Host-facing responder that returns the build's version/timestamp record on request.
- Sits between the host command byte stream (UART RX side) and the response byte stream (UART TX side).
- On receipt of command byte CMD_VERSION, emits one framed, checksummed 14-byte record.
- Other commands are ignored. Requests arriving while a frame is in flight are dropped and flagged.

Parameters:
- VERSION_RECORD, default {major,minor,patch,build,year[15:8],year[7:0],month,day,hour,minute,second} from version_pkg constants, 88-bit payload; byte 0 (major) in bits [87:80].
- CMD_VERSION, default 8'h56, command byte that triggers a report.
- SOF_BYTE, default 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  command byte valid
- s_data  in  8  command byte
- s_ready  out  1  always 1 outside reset; command bytes are never back-pressured
- m_valid  out  1  response byte valid
- m_data  out  8  response byte
- m_ready  in  1  downstream accepts byte when m_valid && m_ready
- busy  out  1  high from command acceptance until the checksum byte transfers
- cmd_drop  out  1  one-cycle pulse when CMD_VERSION arrives while busy

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - m_valid=0, m_data=8'h00, busy=0, cmd_drop=0, state=IDLE, index=0, checksum accumulator=0.
  - s_ready=0 while rst_n low.
- Frame format, 14 bytes:
  - SOF_BYTE, LEN=8'h0B, payload bytes 0..10 of VERSION_RECORD, CHK.
  - CHK = (0 - (LEN + sum of payload bytes)) mod 256, so LEN..CHK sums to 8'h00.
- States: IDLE -> SOF -> LEN -> PAYLOAD -> CHK -> IDLE.
- IDLE:
  - s_valid && s_data==CMD_VERSION loads SOF_BYTE into m_data and sets m_valid=1 and busy=1 on the next edge (latency 1 cycle from command to first m_valid).
  - Any other byte is consumed with no effect.
- Advance: each state advances only on a transfer (m_valid && m_ready). While m_valid && !m_ready, m_data and m_valid hold stable.
- SOF -> LEN: on transfer; m_data becomes 8'h0B and the accumulator loads 8'h0B.
- LEN -> PAYLOAD: on transfer; index=0.
- PAYLOAD:
  - m_data = payload byte[index].
  - On each transfer the accumulator adds byte[index] (8-bit wrap) and index increments.
  - On transfer at index==10, go to CHK with m_data = two's complement of the final accumulator.
- CHK -> IDLE: on transfer; m_valid=0 and busy=0 on the same edge.
  - A command arriving in that same cycle is treated as arriving while busy (dropped).
  - A new request is accepted from the following cycle; frames are therefore separated by at least one idle cycle.
- Back-to-back throughput: 1 byte/cycle when m_ready is held high. With command acceptance at cycle 0, the frame occupies cycles 1..14.
- cmd_drop: asserted for exactly one cycle per CMD_VERSION byte received while busy. Non-matching bytes never pulse it.
- index is a 4-bit counter; values 11..15 are unreachable. If reached, force state=IDLE, m_valid=0.
- Reset mid-frame: outputs return to reset values immediately. No partial frame resumes after reset.

Decomposition:
- Shared package version_proto_pkg holds:
  - CMD_VERSION, SOF_BYTE and LEN constants;
  - the state enum typedef (IDLE, SOF, LEN, PAYLOAD, CHK);
  - a function building the 88-bit record from version_pkg constants.
- No sub-module required. Payload byte selection is an indexed slice of VERSION_RECORD inside this module.

Test Plan:
- VERSION_RECORD=88'h00_00_00_31_20_25_11_05_11_28_19, single s_data=8'h56, m_ready=1:
  - m_valid rises 1 cycle later;
  - stream is A5 0B 00 00 00 31 20 25 11 05 11 28 19 17;
  - busy falls after the 14th byte.
- Same request with m_ready toggling 1,0,0,1 pattern: identical byte sequence; m_data stable on every stalled cycle; no byte duplicated or lost.
- Send 8'h56 at frame byte 5: cmd_drop pulses once and the frame completes unchanged. Send 8'h41 at frame byte 5: no pulse and no effect.
- Two 8'h56 requests separated by 20 idle cycles: two identical 14-byte frames, busy low between them.
- Assert rst_n=0 at payload index 4 for 2 cycles, release, then send 8'h56: outputs go to reset values immediately; the new frame starts with A5 and is complete and correct.
- Idle stream of bytes 8'h00..8'hFF excluding 8'h56: m_valid never asserts, cmd_drop never pulses, s_ready stays 1.
